// File: rtl/encap_header_gen_pkg.sv
// Shared constants, state encoding and header assembly for encap_header_gen.
// ENCAP_SEQ_TAG_EN appends a 16-bit sequence tag to every header.
package encap_header_gen_pkg;

    localparam logic [15:0] TPID_VLAN      = 16'h8100;
    localparam int          HDR_BYTES_BASE = 18;
    localparam int          SEQ_BYTES      = 2;

`ifdef ENCAP_SEQ_TAG_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Byte 0 of the header lands in the most significant byte of the vector.
    function automatic logic [HDR_BYTES_BASE*8-1:0] build_base_hdr(
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [11:0] vid,
        input logic [15:0] ety
    );
        return {dst, src, TPID_VLAN, 4'h0, vid, ety};
    endfunction

endpackage

// File: rtl/encap_pend_counter.sv
// Saturating up/down count of headers owed; flags a request lost at saturation.
module encap_pend_counter #(
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;
    logic              ovf_q;
    logic              ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (inc && !dec) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/encap_header_gen.sv
// Byte-serial tunnel-encapsulation header generator, one header per pkt_req.
// Define ENCAP_SEQ_TAG_EN to append a 16-bit sequence number (MSB first).
module encap_header_gen
    import encap_header_gen_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PEND_W    = 4,
    parameter int HDR_BYTES = HDR_BYTES_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_req,
    input  logic [47:0]       dst_mac,
    input  logic [47:0]       src_mac,
    input  logic [11:0]       vlan_id,
    input  logic [15:0]       etype,
    input  logic              tready,
    output logic              tvalid,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              pend_ovf
);

    localparam int LEN   = HDR_BYTES + (SEQ_EN ? SEQ_BYTES : 0);
    localparam int HDR_W = LEN * DATA_W;
    localparam int IDX_W = $clog2(LEN);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(LEN - 2);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic               tvalid_q, tvalid_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic               tlast_q, tlast_d;
    logic [HDR_W-1:0]   hdr_snap;
    logic               hs;
    logic               last_hs;

    assign hs      = tvalid_q && tready;
    assign last_hs = hs && tlast_q;

    encap_pend_counter #(
        .PEND_W (PEND_W)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .inc   (pkt_req),
        .dec   (last_hs),
        .count (pend_cnt),
        .ovf   (pend_ovf)
    );

`ifdef ENCAP_SEQ_TAG_EN
    logic [15:0] seq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else if (last_hs) begin
            seq_q <= seq_q + 16'd1;
        end
    end

    assign hdr_snap = {build_base_hdr(dst_mac, src_mac, vlan_id, etype), seq_q};
`else
    assign hdr_snap = build_base_hdr(dst_mac, src_mac, vlan_id, etype);
`endif

    // hdr_q holds only the bytes not yet presented; the next one is always at the top.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hdr_d    = hdr_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_cnt != '0) begin
                    hdr_d    = hdr_snap << DATA_W;
                    tdata_d  = hdr_snap[HDR_W-1 -: DATA_W];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                        idx_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        tdata_d = hdr_q[HDR_W-1 -: DATA_W];
                        hdr_d   = hdr_q << DATA_W;
                        tlast_d = (idx_q == PENULT_IDX);
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hdr_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hdr_q    <= hdr_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
    assign tlast  = tlast_q;

endmodule

// File: tb/tb_encap_header_gen.sv
// Scoreboard bench for encap_header_gen: stimulus queues expected bytes, a monitor pops on handshake.
module tb_encap_header_gen;

`ifdef ENCAP_SEQ_TAG_EN
    localparam int LEN = 20;
`else
    localparam int LEN = 18;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_req;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [11:0] vlan_id;
    logic [15:0] etype;
    logic        tready;
    logic        tvalid;
    logic [7:0]  tdata;
    logic        tlast;
    logic [3:0]  pend_cnt;
    logic        pend_ovf;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  exp_q[$];
    logic [15:0] seq_model = 16'h0000;

    // Hand-computed header for dst 00..55, src 66..BB, VID 5A3, ethertype 88B5.
    logic [7:0] hdr_a [18] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                               8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB,
                               8'h81, 8'h00, 8'h05, 8'hA3, 8'h88, 8'hB5};
    // Same header with dst DE AD BE EF 01 02.
    logic [7:0] hdr_b [6]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};

    encap_header_gen dut (
        .clk      (clk),
        .rst      (rst),
        .pkt_req  (pkt_req),
        .dst_mac  (dst_mac),
        .src_mac  (src_mac),
        .vlan_id  (vlan_id),
        .etype    (etype),
        .tready   (tready),
        .tvalid   (tvalid),
        .tdata    (tdata),
        .tlast    (tlast),
        .pend_cnt (pend_cnt),
        .pend_ovf (pend_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seq();
`ifdef ENCAP_SEQ_TAG_EN
        exp_q.push_back({1'b0, seq_model[15:8]});
        exp_q.push_back({1'b1, seq_model[7:0]});
        seq_model = seq_model + 16'd1;
`endif
    endtask

    task automatic push_hdr(input bit use_b);
        logic [7:0] b;
        for (int i = 0; i < 18; i++) begin
            b = (use_b && i < 6) ? hdr_b[i] : hdr_a[i];
            exp_q.push_back({(LEN == 18 && i == 17), b});
        end
        push_seq();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tvalid || pend_cnt != 4'd0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: queued=%0d tvalid=%b pend=%0d", name, exp_q.size(), tvalid, pend_cnt);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!tvalid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!tvalid) begin
            failures++;
            $display("FAIL %s_no_tvalid: tvalid=%b required 1", name, tvalid);
        end
    endtask

    // Monitor: handshake pops, stall stability, one-cycle bubble between headers.
    logic       stall_p  = 1'b0;
    logic [7:0] data_p   = '0;
    logic       last_p   = 1'b0;
    logic       lasths_p = 1'b0;
    logic       bub_p    = 1'b0;
    int         byte_no  = 0;

    always @(negedge clk) begin
        logic [8:0] e;
        logic       bub_n;
        if (rst) begin
            stall_p  <= 1'b0;
            lasths_p <= 1'b0;
            bub_p    <= 1'b0;
            byte_no  <= 0;
        end else begin
            bub_n = 1'b0;
            if (stall_p) begin
                checks++;
                if (!(tvalid && tdata == data_p && tlast == last_p)) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             tvalid, tdata, tlast, data_p, last_p);
                end
            end
            if (bub_p) begin
                checks++;
                if (!tvalid) begin
                    failures++;
                    $display("FAIL bubble_restart: tvalid=%b required 1", tvalid);
                end
            end
            if (lasths_p) begin
                checks++;
                if (tvalid) begin
                    failures++;
                    $display("FAIL bubble_idle: tvalid=%b required 0", tvalid);
                end
                bub_n = (pend_cnt != 4'd0);
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got d=%h l=%b with empty scoreboard", tdata, tlast);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    $display("byte %0d d=%h l=%b exp d=%h l=%b", byte_no, tdata, tlast, e[7:0], e[8]);
                    if ({tlast, tdata} !== e) begin
                        failures++;
                        $display("FAIL hdr_byte: got d=%h l=%b required d=%h l=%b", tdata, tlast, e[7:0], e[8]);
                    end
                end
                byte_no <= tlast ? 0 : byte_no + 1;
            end
            stall_p  <= tvalid && !tready;
            data_p   <= tdata;
            last_p   <= tlast;
            lasths_p <= tvalid && tready && tlast;
            bub_p    <= bub_n;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst     = 1'b1;
        pkt_req = 1'b0;
        dst_mac = 48'h0011_2233_4455;
        src_mac = 48'h6677_8899_AABB;
        vlan_id = 12'h5A3;
        etype   = 16'h88B5;
        tready  = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_pend", 32'(pend_cnt), 32'd0);
        chk("rst_ovf", 32'(pend_ovf), 32'd0);
        rst = 1'b0;
        tick();

        // 1) single header, latency N+2
        push_hdr(1'b0);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        chk("c1_pend_n1", 32'(pend_cnt), 32'd1);
        chk("c1_tvalid_n1", 32'(tvalid), 32'd0);
        tick();
        chk("c1_tvalid_n2", 32'(tvalid), 32'd1);
        chk("c1_first_byte", 32'(tdata), 32'h00);
        wait_drain("c1", 100);
        chk("c1_pend_end", 32'(pend_cnt), 32'd0);

        // 2) tready toggled 1010...
        push_hdr(1'b0);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 200) begin
            tready = ~tready;
            tick();
            n++;
        end
        chk("c2_done", 32'(n < 200), 32'd1);
        tready = 1'b1;
        tick();

        // 3) three consecutive requests
        for (int i = 0; i < 3; i++) push_hdr(1'b0);
        pkt_req = 1'b1;
        repeat (3) tick();
        pkt_req = 1'b0;
        chk("c3_pend3", 32'(pend_cnt), 32'd3);
        wait_drain("c3", 200);
        chk("c3_pend_end", 32'(pend_cnt), 32'd0);

        // 4) request coincident with tlast handshake
        push_hdr(1'b0);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        n = 0;
        while (!(tvalid && tlast) && n < 100) begin
            tick();
            n++;
        end
        chk("c4_reach_last", 32'(tvalid && tlast), 32'd1);
        push_hdr(1'b0);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        chk("c4_pend_coincident", 32'(pend_cnt), 32'd1);
        wait_drain("c4a", 100);

        // 4b) saturation and overflow pulse
        tready = 1'b0;
        for (int i = 0; i < 15; i++) push_hdr(1'b0);
        pkt_req = 1'b1;
        repeat (15) tick();
        pkt_req = 1'b0;
        chk("c4_pend_sat", 32'(pend_cnt), 32'd15);
        chk("c4_ovf_before", 32'(pend_ovf), 32'd0);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        chk("c4_ovf_pulse", 32'(pend_ovf), 32'd1);
        chk("c4_pend_hold", 32'(pend_cnt), 32'd15);
        tick();
        chk("c4_ovf_clear", 32'(pend_ovf), 32'd0);
        chk("c4_pend_hold2", 32'(pend_cnt), 32'd15);
        tready = 1'b1;
        wait_drain("c4b", 600);

        // 5) dst_mac change mid-header
        push_hdr(1'b0);
        push_hdr(1'b1);
        pkt_req = 1'b1;
        repeat (2) tick();
        pkt_req = 1'b0;
        wait_valid("c5");
        repeat (3) tick();
        dst_mac = 48'hDEAD_BEEF_0102;
        wait_drain("c5", 100);
        dst_mac = 48'h0011_2233_4455;

        // 6) reset while byte 7 is presented
        push_hdr(1'b0);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        wait_valid("c6");
        repeat (6) tick();
        chk("c6_byte7", 32'(tdata), 32'h66);
        rst = 1'b1;
        tick();
        chk("c6_tvalid", 32'(tvalid), 32'd0);
        chk("c6_tlast", 32'(tlast), 32'd0);
        chk("c6_pend", 32'(pend_cnt), 32'd0);
        exp_q.delete();
        seq_model = 16'h0000;
        rst = 1'b0;
        tick();
        push_hdr(1'b0);
        pkt_req = 1'b1;
        tick();
        pkt_req = 1'b0;
        wait_drain("c6_recover", 100);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
